// File: rtl/dacad5668_pkg.sv
// AD5668 scheduler shared definitions: command codes, FSM states, init frame and frame packing.
// Frame layout: [31:28]=0, [27:24]=cmd, [23:20]=addr, [19:4]=code, [3:0]=feature.
package dacad5668_pkg;

    localparam int NUM_CH  = 8;
    localparam int DATA_W  = 16;
    localparam int FRAME_W = 32;
    localparam int CH_W    = 3;

    localparam logic [3:0] CMD_WR_IN      = 4'b0000;
    localparam logic [3:0] CMD_WR_UPD_ALL = 4'b0010;
    localparam logic [3:0] CMD_WR_UPD_N   = 4'b0011;

    // Internal reference setup: cmd 1000, feature bit 0 set.
    localparam logic [FRAME_W-1:0] INIT_FRAME = 32'h0800_0001;

    typedef enum logic [2:0] {
        ST_INIT_SEND,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_t;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [3:0]        cmd,
        input logic [CH_W-1:0]   ch,
        input logic [DATA_W-1:0] code
    );
        return {4'h0, cmd, 1'b0, ch, code, 4'h0};
    endfunction

endpackage

// File: rtl/dacad5668_rr_arbiter.sv
// Round-robin pick of the first set pending bit at or after rr_ptr, wrapping 7 -> 0.
// Purely combinational; any flags that a grant exists.
module dacad5668_rr_arbiter
    import dacad5668_pkg::*;
(
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [CH_W-1:0]   grant,
    output logic              any
);

    logic [CH_W-1:0] idx;
    logic            found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = rr_ptr + CH_W'(i);
            if (!found && pending[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |pending;

endmodule

// File: rtl/dacad5668_scheduler.sv
// AD5668 frame scheduler: init frame after reset, then round-robin data frames; write N -> frm_valid N+2.
// frm_valid/frm_data held until frm_ready, next frame only after frm_done; DACAD5668_SIMUL_UPDATE_EN selects simultaneous update.
module dacad5668_scheduler
    import dacad5668_pkg::*;
(
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               wr_valid,
    input  logic [CH_W-1:0]    wr_ch,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               frm_valid,
    input  logic               frm_ready,
    output logic [FRAME_W-1:0] frm_data,
    input  logic               frm_done,
    output logic [NUM_CH-1:0]  pending,
    output logic               busy
);

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   arb_grant;
    logic              arb_any;
    logic [DATA_W-1:0] shadow [NUM_CH];
    logic              redirty;
    logic              handshake;
    logic              wr_hit_grant;
    logic [DATA_W-1:0] grant_code;
    logic [3:0]        grant_cmd;

    dacad5668_rr_arbiter u_arb (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .grant   (arb_grant),
        .any     (arb_any)
    );

    assign handshake    = frm_valid && frm_ready;
    assign wr_hit_grant = wr_valid && (wr_ch == grant);
    // A write landing in the grant cycle is forwarded so the newest code goes out.
    assign grant_code   = (wr_valid && (wr_ch == arb_grant)) ? wr_data : shadow[arb_grant];

`ifdef DACAD5668_SIMUL_UPDATE_EN
    logic [NUM_CH-1:0] others;
    assign others    = pending & ~(NUM_CH'(1) << arb_grant);
    assign grant_cmd = (|others) ? CMD_WR_IN : CMD_WR_UPD_ALL;
`else
    assign grant_cmd = CMD_WR_UPD_N;
`endif

    // Pending clears on handshake unless the channel was rewritten since its grant.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pending <= '0;
            for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
        end else begin
            if (state == ST_SEND && handshake && !redirty) pending[grant] <= 1'b0;
            if (wr_valid) begin
                shadow[wr_ch]  <= wr_data;
                pending[wr_ch] <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= ST_INIT_SEND;
            frm_valid <= 1'b0;
            frm_data  <= '0;
            busy      <= 1'b1;
            rr_ptr    <= '0;
            grant     <= '0;
            redirty   <= 1'b0;
        end else begin
            case (state)
                ST_INIT_SEND: begin
                    if (handshake) begin
                        frm_valid <= 1'b0;
                        state     <= ST_INIT_WAIT;
                    end else begin
                        frm_valid <= 1'b1;
                        frm_data  <= INIT_FRAME;
                    end
                end
                ST_INIT_WAIT, ST_WAIT: begin
                    if (frm_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (arb_any) begin
                        grant     <= arb_grant;
                        rr_ptr    <= arb_grant + CH_W'(1);
                        frm_data  <= pack_frame(grant_cmd, arb_grant, grant_code);
                        frm_valid <= 1'b1;
                        busy      <= 1'b1;
                        redirty   <= 1'b0;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (wr_hit_grant) redirty <= 1'b1;
                    if (handshake) begin
                        frm_valid <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                default: begin
                    state     <= ST_INIT_SEND;
                    frm_valid <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dacad5668_scheduler.sv
// Directed bench for dacad5668_scheduler: cycle table for the main flows, hand sequence for mid-frame reset.
module tb_dacad5668_scheduler;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        wr_valid;
    logic [2:0]  wr_ch;
    logic [15:0] wr_data;
    logic        frm_valid;
    logic        frm_ready;
    logic [31:0] frm_data;
    logic        frm_done;
    logic [7:0]  pending;
    logic        busy;

    dacad5668_scheduler dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .wr_valid  (wr_valid),
        .wr_ch     (wr_ch),
        .wr_data   (wr_data),
        .frm_valid (frm_valid),
        .frm_ready (frm_ready),
        .frm_data  (frm_data),
        .frm_done  (frm_done),
        .pending   (pending),
        .busy      (busy)
    );

    always #5 ACLK = ~ACLK;

    localparam logic [31:0] INIT = 32'h0800_0001;
`ifdef DACAD5668_SIMUL_UPDATE_EN
    localparam logic [3:0] C1 = 4'b0010;
    localparam logic [3:0] CM = 4'b0000;
`else
    localparam logic [3:0] C1 = 4'b0011;
    localparam logic [3:0] CM = 4'b0011;
`endif

    typedef struct {
        logic        wv;
        logic [2:0]  wch;
        logic [15:0] wd;
        logic        rdy;
        logic        dn;
        logic        ev;
        logic [31:0] ed;
        logic [7:0]  ep;
        logic        eb;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] fr(input logic [3:0] c, input logic [2:0] ch, input logic [15:0] d);
        return {4'h0, c, 1'b0, ch, d, 4'h0};
    endfunction

    task automatic add(input logic wv, input logic [2:0] wch, input logic [15:0] wd,
                       input logic rdy, input logic dn, input logic ev,
                       input logic [31:0] ed, input logic [7:0] ep, input logic eb);
        vec_t v;
        v = '{wv, wch, wd, rdy, dn, ev, ed, ep, eb};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        bit got;

        // Reset release, init frame, frm_done ten cycles after handshake; stray done/ready in IDLE.
        add(0,0,16'h0,1,0, 1,INIT,8'h00,1);
        add(0,0,16'h0,1,0, 0,32'h0,8'h00,1);
        for (int i = 0; i < 8; i++) add(0,0,16'h0,1,0, 0,32'h0,8'h00,1);
        add(0,0,16'h0,1,1, 0,32'h0,8'h00,0);
        add(0,0,16'h0,1,1, 0,32'h0,8'h00,0);
        // ch3 = ABCD, frm_done during SEND ignored.
        add(1,3,16'hABCD,0,0, 0,32'h0,8'h08,0);
        add(0,0,16'h0,0,1, 1,fr(C1,3,16'hABCD),8'h08,1);
        add(0,0,16'h0,1,0, 0,32'h0,8'h00,1);
        add(0,0,16'h0,0,1, 0,32'h0,8'h00,0);
        // ch4 held five cycles without ready, leaves rr_ptr = 5.
        add(1,4,16'h4444,0,0, 0,32'h0,8'h10,0);
        add(0,0,16'h0,0,0, 1,fr(C1,4,16'h4444),8'h10,1);
        for (int i = 0; i < 5; i++) add(0,0,16'h0,0,(i == 2), 1,fr(C1,4,16'h4444),8'h10,1);
        add(0,0,16'h0,1,0, 0,32'h0,8'h00,1);
        // ch7 and ch0 written during WAIT: wrap order 7 then 0.
        add(1,7,16'h1111,0,0, 0,32'h0,8'h80,1);
        add(1,0,16'h2222,0,0, 0,32'h0,8'h81,1);
        add(0,0,16'h0,0,1, 0,32'h0,8'h81,0);
        add(0,0,16'h0,0,0, 1,fr(CM,7,16'h1111),8'h81,1);
        add(0,0,16'h0,1,0, 0,32'h0,8'h01,1);
        add(0,0,16'h0,0,1, 0,32'h0,8'h01,0);
        add(0,0,16'h0,0,0, 1,fr(C1,0,16'h2222),8'h01,1);
        add(0,0,16'h0,1,0, 0,32'h0,8'h00,1);
        add(0,0,16'h0,0,1, 0,32'h0,8'h00,0);
        // ch2 rewritten during WAIT of its own frame.
        add(1,2,16'h0001,0,0, 0,32'h0,8'h04,0);
        add(0,0,16'h0,0,0, 1,fr(C1,2,16'h0001),8'h04,1);
        add(0,0,16'h0,1,0, 0,32'h0,8'h00,1);
        add(1,2,16'h0002,0,0, 0,32'h0,8'h04,1);
        add(0,0,16'h0,0,1, 0,32'h0,8'h04,0);
        add(0,0,16'h0,0,0, 1,fr(C1,2,16'h0002),8'h04,1);
        add(0,0,16'h0,1,0, 0,32'h0,8'h00,1);
        add(0,0,16'h0,0,1, 0,32'h0,8'h00,0);
        // ch5 rewritten in the handshake cycle: pending stays, new code follows.
        add(1,5,16'h5555,0,0, 0,32'h0,8'h20,0);
        add(0,0,16'h0,0,0, 1,fr(C1,5,16'h5555),8'h20,1);
        add(1,5,16'h6666,1,0, 0,32'h0,8'h20,1);
        add(0,0,16'h0,0,1, 0,32'h0,8'h20,0);
        add(0,0,16'h0,0,0, 1,fr(C1,5,16'h6666),8'h20,1);
        add(0,0,16'h0,1,0, 0,32'h0,8'h00,1);
        add(0,0,16'h0,0,1, 0,32'h0,8'h00,0);
        // ch6 rewritten during SEND: frame in flight unchanged, resent afterwards.
        add(1,6,16'h0606,0,0, 0,32'h0,8'h40,0);
        add(0,0,16'h0,0,0, 1,fr(C1,6,16'h0606),8'h40,1);
        add(1,6,16'h0707,0,0, 1,fr(C1,6,16'h0606),8'h40,1);
        add(0,0,16'h0,1,0, 0,32'h0,8'h40,1);
        add(0,0,16'h0,0,1, 0,32'h0,8'h40,0);
        add(0,0,16'h0,0,0, 1,fr(C1,6,16'h0707),8'h40,1);
        add(0,0,16'h0,1,0, 0,32'h0,8'h00,1);
        add(0,0,16'h0,0,1, 0,32'h0,8'h00,0);
        // Back-to-back writes to ch1 coalesce; only the last code is sent.
        add(1,1,16'h1000,0,0, 0,32'h0,8'h02,0);
        add(1,1,16'h1001,0,0, 1,fr(C1,1,16'h1001),8'h02,1);
        add(0,0,16'h0,1,0, 0,32'h0,8'h00,1);
        add(0,0,16'h0,0,1, 0,32'h0,8'h00,0);

        ARESETN = 1'b0; wr_valid = 0; wr_ch = 0; wr_data = 0; frm_ready = 0; frm_done = 0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_valid",   {31'h0, frm_valid}, 32'h0);
        chk("rst_data",    frm_data,           32'h0);
        chk("rst_pending", {24'h0, pending},   32'h0);
        chk("rst_busy",    {31'h0, busy},      32'h1);
        ARESETN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            wr_valid = vecs[i].wv; wr_ch = vecs[i].wch; wr_data = vecs[i].wd;
            frm_ready = vecs[i].rdy; frm_done = vecs[i].dn;
            tick();
            chk($sformatf("row%0d_valid", i),   {31'h0, frm_valid}, {31'h0, vecs[i].ev});
            chk($sformatf("row%0d_pending", i), {24'h0, pending},   {24'h0, vecs[i].ep});
            chk($sformatf("row%0d_busy", i),    {31'h0, busy},      {31'h0, vecs[i].eb});
            if (vecs[i].ev) chk($sformatf("row%0d_data", i), frm_data, vecs[i].ed);
        end
        wr_valid = 0; frm_ready = 0; frm_done = 0;

        // Reset during WAIT with ch5 pending; init frame must precede the ch6 data frame.
        wr_valid = 1; wr_ch = 3; wr_data = 16'h1234;
        tick();
        wr_valid = 0;
        tick();
        frm_ready = 1;
        tick();
        frm_ready = 0; wr_valid = 1; wr_ch = 5; wr_data = 16'h5A5A;
        tick();
        wr_valid = 0;
        chk("pre_rst_pending", {24'h0, pending}, 32'h20);
        chk("pre_rst_busy",    {31'h0, busy},    32'h1);
        ARESETN = 1'b0;
        #2;
        chk("mid_rst_valid",   {31'h0, frm_valid}, 32'h0);
        chk("mid_rst_data",    frm_data,           32'h0);
        chk("mid_rst_pending", {24'h0, pending},   32'h0);
        chk("mid_rst_busy",    {31'h0, busy},      32'h1);
        tick();
        ARESETN = 1'b1; wr_valid = 1; wr_ch = 6; wr_data = 16'h0600;
        tick();
        wr_valid = 0;
        chk("rel_valid",   {31'h0, frm_valid}, 32'h1);
        chk("rel_data",    frm_data,           INIT);
        chk("rel_pending", {24'h0, pending},   32'h40);
        frm_ready = 1;
        tick();
        frm_ready = 0;
        chk("rel_init_wait_valid", {31'h0, frm_valid}, 32'h0);
        frm_done = 1;
        tick();
        frm_done = 0;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (frm_valid) got = 1;
            else tick();
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL rel_data_timeout: frm_valid never rose, expected within 10 cycles");
        end else begin
            chk("rel_data_frame", frm_data, fr(C1, 6, 16'h0600));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dacad5668_scheduler.md
DACAD5668_SCHEDULER -- requirements
Module: dacad5668_scheduler

Interface
REQ-001 NUM_CH, 8, number of DAC channels; fixed at 8 for AD5668.
REQ-002 DATA_W, 16, channel code width.
REQ-003 FRAME_W, 32, SPI frame width handed to the serializer.
REQ-004 ACLK  in  1  single clock; all logic rising-edge.
REQ-005 ARESETN  in  1  asynchronous, active-low reset.
REQ-006 wr_valid  in  1  channel write strobe from AXI register bank; always accepted.
REQ-007 wr_ch  in  3  target channel of write.
REQ-008 wr_data  in  DATA_W  channel code.
REQ-009 frm_valid  out  1  frame available to SPI serializer.
REQ-010 frm_ready  in  1  serializer accepts frame.
REQ-011 frm_data  out  FRAME_W  frame: [31:28]=0, [27:24]=cmd, [23:20]=addr, [19:4]=data, [3:0]=feature.
REQ-012 frm_done  in  1  one-cycle pulse when serializer finishes frame (SYNC high).
REQ-013 pending  out  NUM_CH  per-channel "code not yet sent" flags.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 States SHALL be INIT_SEND, INIT_WAIT, IDLE, SEND, WAIT.
REQ-016 INIT_SEND SHALL present reference-setup frame 0x0800_0001 with frm_valid=1; on frm_ready -> INIT_WAIT.
REQ-017 INIT_WAIT/WAIT SHALL hold until frm_done, then -> IDLE.
REQ-018 wr_valid SHALL store wr_data in shadow[wr_ch] and set pending[wr_ch] at the next edge, in any state.
REQ-019 IDLE with pending!=0 SHALL grant the first pending channel at or after rr_ptr (wrapping 7->0), latch frame, -> SEND; write in cycle N gives frm_valid in cycle N+2.
REQ-020 Grant SHALL set rr_ptr to (grant+1) mod 8; rr_ptr resets to 0.
REQ-021 SEND SHALL hold frm_valid=1 and frm_data stable until frm_ready; on handshake clear pending[grant] and -> WAIT.
REQ-022 A write to the granted channel in the handshake cycle SHALL win: pending stays set, new data is sent later.
REQ-023 A write to the granted channel during SEND or WAIT SHALL not alter the frame in flight.
REQ-024 frm_done outside INIT_WAIT/WAIT SHALL be ignored; frm_ready without frm_valid SHALL be ignored.
REQ-025 Without the macro, data frames SHALL use cmd 0011 (write and update channel n), addr=grant.
REQ-026 Writes to the same channel before send SHALL coalesce; only the last code is sent.

Reset
REQ-027 On ARESETN low: state=INIT_SEND, frm_valid=0, frm_data=0, pending=0, busy=1, rr_ptr=0, shadows=0.
REQ-028 Reset mid-frame SHALL abandon the frame; after release, the init frame is re-sent before any data frame.
REQ-029 frm_valid SHALL assert the first cycle after reset release.

Configuration
REQ-030 Macro DACAD5668_SIMUL_UPDATE_EN, when defined: grants with other pending channels remaining use cmd 0000 (write input register); the grant that empties pending uses cmd 0010 (write n, update all), so all outputs change together.
REQ-031 Macro undefined: REQ-025 behaviour only; no extra logic.

Structure
REQ-032 Package dacad5668_pkg SHALL hold command codes, state enum, init frame constant and a frame-pack function.
REQ-033 Sub-module dacad5668_rr_arbiter SHALL compute the round-robin grant from pending and rr_ptr (combinational, 8-bit).

Verification
REQ-034 Reset release, frm_ready=1, frm_done 10 cycles later -> single frame 0x0800_0001, then busy=0.
REQ-035 Write ch3=0xABCD -> frm_valid at write+2, frm_data=0x033A_BCD0, pending[3] cleared on handshake.
REQ-036 Writes ch7=0x1111, ch0=0x2222 same idle period, rr_ptr=5 -> order ch7 then ch0 (wrap), frames 0x0371_1110, 0x0302_2220.
REQ-037 Write ch2=0x0001 then ch2=0x0002 during WAIT of ch2 frame -> second frame 0x0320_0020; hold frm_ready=0 for 5 cycles -> frm_data stable.
REQ-038 With DACAD5668_SIMUL_UPDATE_EN, writes ch1, ch4 together -> frames cmd 0000 addr 1, then cmd 0010 addr 4.
REQ-039 Assert ARESETN low during WAIT -> outputs at reset values immediately; after release init frame precedes any data frame.
